// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell and a registered borrow, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sd;
    logic             br;
    logic [CW-1:0]    count;
    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] sd_cat;
    logic             last_bit;

    assign cell_diff   = sa[0] ^ sb[0] ^ br;
    assign cell_borrow = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    // sd only keeps the WIDTH-1 bits already produced; the current cell bit completes it.
    assign sd_cat      = {cell_diff, sd};
    assign last_bit    = (count == CW'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift datapath; results are only published on the completing edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            count  <= '0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= z;
                        sd    <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    sd    <= sd_cat[WIDTH-1:1];
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    br    <= cell_borrow;
                    count <= count + 1'b1;
                    if (last_bit) begin
                        diff   <= sd_cat;
                        borrow <= cell_borrow;
`ifdef SERIAL_SUB_OVF_EN
                        // br here is the borrow into the MSB cell.
                        ovf    <= br ^ cell_borrow;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): vector table plus mid-run start and reset sequences.
module tb_serial_sub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       z;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       z;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[9];

    serial_sub #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .z      (z),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
        .borrow (borrow),
        .ovf    (ovf)
`else
        .borrow (borrow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one start pulse; returns at the falling edge just after the accepting edge.
    task automatic apply_stimulus(input logic [7:0] va, input logic [7:0] vb, input logic vz);
        @(negedge clk);
        a     = va;
        b     = vb;
        z     = vz;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_result(input logic [7:0] ed, input logic eb, input logic eo);
        check("done_pulse", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("diff", diff, ed);
        check("borrow", borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", ovf, eo);
`else
        if (eo === 1'bx) check("ovf_unknown", eo, 1'b0);
`endif
    endtask

    task automatic check_output(input logic [7:0] ed, input logic eb, input logic eo);
        for (int i = 0; i < 8; i++) begin
            check("busy_run", busy, 1'b1);
            check("no_early_done", done, 1'b0);
            @(negedge clk);
        end
        check_result(ed, eb, eo);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        z        = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'hC8, 8'h37, 1'b1, 8'h90, 1'b0, 1'b0};

        @(negedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_diff", diff, 8'h00);
        check("reset_borrow", borrow, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", ovf, 1'b0);
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_no_done", done, 1'b0);
            check("idle_no_busy", busy, 1'b0);
        end

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].z);
            check_output(vecs[i].d, vecs[i].bo, vecs[i].ov);
        end

        // Start re-asserted mid-run must be ignored and only accepted once back in IDLE.
        apply_stimulus(8'h10, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        a     = 8'h00;
        b     = 8'hFF;
        start = 1'b1;
        for (int i = 3; i < 8; i++) begin
            check("busy_run_ign", busy, 1'b1);
            check("no_done_ign", done, 1'b0);
            @(negedge clk);
        end
        check_result(8'h0F, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_k9_busy", busy, 1'b0);
        check("idle_k9_done", done, 1'b0);
        @(negedge clk);
        check("accept_k10", busy, 1'b1);
        start = 1'b0;
        @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            check("busy_run_2", busy, 1'b1);
            check("no_done_2", done, 1'b0);
            @(negedge clk);
        end
        check_result(8'h01, 1'b1, 1'b0);

        // Reset in the middle of a run aborts with no done pulse.
        apply_stimulus(8'h40, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_diff", diff, 8'h00);
        check("abort_borrow", borrow, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", ovf, 1'b0);
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
            check("abort_no_busy", busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
